// File: rtl/mips_harvard_bus_sequencer.sv
// mips_harvard_bus_sequencer
//
// Lets the instruction port and the data port of mips_cpu_harvard share one
// single-port memory bus whose latency varies. The CPU is held through
// clk_enable while this block fetches the instruction and then performs the
// data access that instruction asks for, if any. The CPU is then released
// for exactly one clock edge.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   cpu_active          CPU still running; sampled once per instruction in NEXT
//   clk_enable          CPU clock enable, high only in the RUN cycle
//   instr_address       CPU fetch address
//   instr_readdata      registered fetched instruction
//   data_address        CPU data address (derived from instr_readdata)
//   data_read/write     CPU data request strobes
//   data_writedata      CPU store data
//   data_readdata       registered load data
//   mem_address         memory bus address
//   mem_read/mem_write  memory strobes, never both high
//   mem_writedata       memory write data
//   mem_waitrequest     memory stall
//   mem_readdata        memory read data, valid in the completing cycle
//   halted              sticky halt indication
//   bus_error           sticky timeout / conflicting-request flag
//
// Bus handshake: a strobe (mem_read or mem_write), together with mem_address
// and mem_writedata, is the request and stays stable while mem_waitrequest
// is high. The transfer completes on the first clock edge where the strobe
// is high and mem_waitrequest is low. If MAX_WAIT consecutive cycles pass
// with mem_waitrequest high, the transfer is abandoned and the block halts.
module mips_harvard_bus_sequencer #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_active,
   output logic        clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_write,
   input  logic        data_read,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic        halted,
   output logic        bus_error
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_CHECK = 3'd1,
      ST_DATA  = 3'd2,
      ST_RUN   = 3'd3,
      ST_NEXT  = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
   logic [31:0]     req_addr, req_wdata;
   logic            req_wr;
   logic            load_instr, load_data, latch_req, set_berr;
   logic            xfer, wait_expired;

   // This cycle is the last one allowed with waitrequest high.
   assign wait_expired = (wait_cnt == CW'(MAX_WAIT - 1));

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      load_instr    = 1'b0;
      load_data     = 1'b0;
      latch_req     = 1'b0;
      set_berr      = 1'b0;
      xfer          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = 32'd0;
      mem_writedata = 32'd0;
      clk_enable    = 1'b0;
      halted        = 1'b0;

      case (state)
         ST_FETCH: begin
            xfer        = 1'b1;
            mem_read    = 1'b1;
            mem_address = instr_address;
            if (!mem_waitrequest) begin
               load_instr = 1'b1;
               state_nxt  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (data_read || data_write) begin
               latch_req = 1'b1;
               state_nxt = ST_DATA;
               // A write wins over a simultaneous read; the conflict is flagged.
               if (data_read && data_write) set_berr = 1'b1;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_DATA: begin
            xfer          = 1'b1;
            mem_address   = req_addr;
            mem_write     = req_wr;
            mem_read      = !req_wr;
            mem_writedata = req_wr ? req_wdata : 32'd0;
            if (!mem_waitrequest) begin
               load_data = !req_wr;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            clk_enable = 1'b1;
            state_nxt  = ST_NEXT;
         end
         ST_NEXT: begin
            state_nxt = cpu_active ? ST_FETCH : ST_HALT;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = ST_HALT;
      endcase

      // Shared wait-state accounting for FETCH and DATA transfers.
      if (xfer) begin
         if (!mem_waitrequest) begin
            wait_cnt_nxt = '0;
         end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
            if (wait_expired) begin
               set_berr  = 1'b1;
               state_nxt = ST_HALT;
            end
         end
      end

      // While reset is held nothing may reach the bus or the CPU.
      if (reset) begin
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         mem_address   = 32'd0;
         mem_writedata = 32'd0;
         clk_enable    = 1'b0;
         halted        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_FETCH;
         wait_cnt       <= '0;
         instr_readdata <= 32'd0;
         data_readdata  <= 32'd0;
         bus_error      <= 1'b0;
         req_addr       <= 32'd0;
         req_wdata      <= 32'd0;
         req_wr         <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (load_instr) instr_readdata <= mem_readdata;
         if (load_data)  data_readdata  <= mem_readdata;
         if (latch_req) begin
            req_addr  <= data_address;
            req_wdata <= data_writedata;
            req_wr    <= data_write;
         end
         if (set_berr) bus_error <= 1'b1;
      end
   end

endmodule

// File: doc/mips_harvard_bus_sequencer.md
Name: mips_harvard_bus_sequencer

Overview:
- Shares one single-port, variable-latency memory bus between the instruction and data ports of mips_cpu_harvard.
- Stalls the CPU through clk_enable, fetches the instruction, then performs any data access the fetched instruction requests.
- Releases the CPU for exactly one clock edge per instruction.
- Sits between cpuInst and a wait-state RAM, replacing the dual-port zero-delay RAM model in the bus-level benches.

Parameters:
MAX_WAIT, 255, max consecutive cycles mem_waitrequest may stay high on one transfer before abort.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
cpu_active  input  1  CPU active flag.
clk_enable  output  1  CPU clock enable; high for one cycle per instruction.
instr_address  input  32  CPU instruction address.
instr_readdata  output  32  registered fetched instruction, held stable to CPU.
data_address  input  32  CPU data address; combinational from instr_readdata.
data_write  input  1  CPU data write request.
data_read  input  1  CPU data read request.
data_writedata  input  32  CPU store data.
data_readdata  output  32  registered load data, held stable to CPU.
mem_address  output  32  memory bus address.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
mem_writedata  output  32  memory write data.
mem_waitrequest  input  1  memory stall; transfer completes in a cycle where it is 0.
mem_readdata  input  32  memory read data, valid in the completing cycle.
halted  output  1  sequencer halted; sticky until reset.
bus_error  output  1  sticky timeout or protocol error flag.

Behaviour:
- Reset (sync, high): state=FETCH; all outputs 0, including instr_readdata, data_readdata, halted and bus_error; wait counter=0. Reset asserted mid-transfer drops mem_read/mem_write on the following cycle; no completion is recorded.
- States: FETCH, CHECK, DATA, RUN, NEXT, HALT.
- FETCH:
  - Drive mem_read=1, mem_address=instr_address.
  - On the edge where mem_waitrequest=0: instr_readdata<=mem_readdata; go to CHECK.
- CHECK:
  - No bus activity; CPU data_* outputs settle from the new instr_readdata.
  - Sample data_read/data_write: if either is high -> DATA, latching address/write data/direction into internal registers; else -> RUN.
- DATA:
  - Drive latched request: mem_address, mem_write or mem_read, mem_writedata.
  - Hold strobes and address stable until mem_waitrequest=0.
  - On a read completion: data_readdata<=mem_readdata. On a write completion: data_readdata is unchanged.
  - Then -> RUN.
- RUN: clk_enable=1 for exactly this cycle; CPU advances on its closing edge. -> NEXT.
- NEXT:
  - Absorbs the CPU's post-edge update.
  - If cpu_active=0 -> HALT, else -> FETCH.
- HALT: halted=1; clk_enable=0; mem strobes 0; remains until reset.
- clk_enable is 0 in every state except RUN.
- mem_read and mem_write are never both 1; both are 0 outside FETCH/DATA.
- Simultaneous data_read and data_write in CHECK: write is performed, read is ignored, bus_error<=1 (sticky); sequence continues.
- Wait counter:
  - Increments each FETCH/DATA cycle with mem_waitrequest=1; clears on completion.
  - If the count reaches MAX_WAIT while waitrequest is still high: drop strobes, bus_error<=1, -> HALT.
- Latency with zero wait states, edges from FETCH entry to the RUN edge:
  - No data access: 3 (FETCH, CHECK, RUN).
  - Load/store: 4.
  - Each wait cycle adds 1.
- The first cycle after reset deasserts is FETCH; cpu_active is not checked before the first instruction.

Test Plan:
- Reset then ALU instruction at 0xBFC00000, waitrequest=0 -> mem_read=1 @0xBFC00000 in cycle 1; clk_enable=1 only in cycle 3; no mem_write.
- Load, data_address=0x00001000, mem_readdata=0xDEADBEEF, waitrequest=0 -> DATA read @0x1000 in cycle 3; data_readdata=0xDEADBEEF before the RUN cycle; clk_enable high in cycle 4 only.
- Store 0x12345678 to 0x2000, waitrequest high 3 cycles -> mem_write, address and data stable for 4 cycles; data_readdata unchanged; clk_enable asserted 3 cycles later than the zero-wait case.
- waitrequest stuck high, MAX_WAIT=4 -> strobes drop after 4 wait cycles; bus_error=1; halted=1; clk_enable stays 0.
- CPU drives data_read=data_write=1 -> exactly one mem_write pulse sequence, no mem_read; bus_error=1; execution continues.
- cpu_active falls after a RUN -> HALT entered in NEXT; halted=1. Reset asserted mid-FETCH with waitrequest=1 -> mem_read=0 next cycle, all outputs 0, clean FETCH restart.
